// File: rtl/booth_divider.sv
// booth_divider: sequential signed restoring divider.
// Divides a 2N-bit signed dividend by an N-bit signed divisor, producing one
// quotient bit per clock. The quotient is truncated toward zero and the
// remainder takes the sign of the dividend. Latency is fixed from the
// accepting edge to done, including divide-by-zero and overflow cases.
module booth_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W) + 1;

    localparam logic [W-1:0]  ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]    ONE_N1    = {{N{1'b0}}, 1'b1};
    localparam logic [W-1:0]  MIN_W     = {1'b1, {(W-1){1'b0}}};
    localparam logic [N-1:0]  NEG_ONE_N = {N{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Magnitude of the dividend; the most-negative value maps to 2^(W-1) unsigned.
    function automatic logic [W-1:0] abs_dividend(input logic [W-1:0] v);
        return v[W-1] ? (~v + ONE_W) : v;
    endfunction

    // Magnitude of the divisor, widened by one bit so -2^(N-1) fits unsigned.
    function automatic logic [N:0] abs_divisor(input logic [N-1:0] v);
        logic [N:0] ext;
        ext = {v[N-1], v};
        return ext[N] ? (~ext + ONE_N1) : ext;
    endfunction

    // Two's-complement negation at quotient width.
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Two's-complement negation at remainder width.
    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + ONE_N;
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_dvd;        // dividend magnitude shifting out, quotient bits shifting in
    logic [N:0]      r_rem;        // partial remainder
    logic [N:0]      r_dvs;        // divisor magnitude
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dbz_p;
    logic            r_ovf_p;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_div_by_zero;
    logic            r_overflow;

    logic [N:0]      w_shift;
    logic [N+1:0]    w_trial;
    logic            w_trial_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: fixed-length sequence once a request is accepted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Trial subtraction: shift in the next dividend bit, subtract the divisor.
    always_comb begin
        w_shift    = {r_rem[N-1:0], r_dvd[W-1]};
        w_trial    = {1'b0, w_shift} - {1'b0, r_dvs};
        w_trial_ok = ~w_trial[N+1];
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd         <= {W{1'b0}};
            r_rem         <= {(N+1){1'b0}};
            r_dvs         <= {(N+1){1'b0}};
            r_cnt         <= {CW{1'b0}};
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dbz_p       <= 1'b0;
            r_ovf_p       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= {W{1'b0}};
            r_remainder   <= {N{1'b0}};
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_neg_q <= dividend[W-1] ^ divisor[N-1];
                        r_neg_r <= dividend[W-1];
                        r_dvd   <= abs_dividend(dividend);
                        r_dvs   <= abs_divisor(divisor);
                        r_rem   <= {(N+1){1'b0}};
                        r_cnt   <= {CW{1'b0}};
                        r_dbz_p <= (divisor == {N{1'b0}});
                        r_ovf_p <= (dividend == MIN_W) && (divisor == NEG_ONE_N);
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_dvd <= {r_dvd[W-2:0], w_trial_ok};
                    if (w_trial_ok) begin
                        r_rem <= w_trial[N:0];
                    end else begin
                        r_rem <= w_shift;
                    end
                    r_cnt <= r_cnt + CNT_ONE;
                end
                S_FIX: begin
                    if (r_dbz_p) begin
                        r_quotient    <= {W{1'b0}};
                        r_remainder   <= {N{1'b0}};
                        r_div_by_zero <= 1'b1;
                        r_overflow    <= 1'b0;
                    end else begin
                        r_quotient    <= r_neg_q ? neg_w(r_dvd) : r_dvd;
                        r_remainder   <= r_neg_r ? neg_n(r_rem[N-1:0]) : r_rem[N-1:0];
                        r_div_by_zero <= 1'b0;
                        // -2^(W-1) / -1 leaves magnitude 2^(W-1), which already reads as the wrapped pattern
                        r_overflow    <= r_ovf_p;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider (N=4): directed vectors push expected
// results; a monitor pops and compares on every done pulse.
module tb_booth_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    booth_divider #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
        int         acc;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_done  = 0;
    logic [7:0] last_q  = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latency can be measured from the acceptance edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_quot"}, {24'd0, quotient}, {24'd0, e.q});
                chk({e.name, "_rem"},  {28'd0, remainder}, {28'd0, e.r});
                chk({e.name, "_dbz"},  {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk({e.name, "_ovf"},  {31'd0, overflow}, {31'd0, e.ovf});
                chk({e.name, "_lat"},  cyc - e.acc, 32'd10);
                chk({e.name, "_busy_low"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    // Issue one division; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] q, input logic [3:0] r,
                         input logic dz, input logic ov, input string nm);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q = q; e.r = r; e.dbz = dz; e.ovf = ov; e.acc = cyc + 1; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        chk({nm, "_busy_start"}, {31'd0, busy}, 32'd1);
        chk({nm, "_hold_q"}, {24'd0, quotient}, {24'd0, last_q});
        last_q = q;
    endtask

    // Wait (bounded) for all expected results to be consumed.
    task automatic drain(input string nm);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk({nm, "_drain"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", {24'd0, quotient}, 32'd0);
        chk("rst_rem",  {28'd0, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;

        // 35/5 with busy profile across the whole operation
        issue(8'd35, 4'd5, 8'd7, 4'd0, 1'b0, 1'b0, "d35_5");
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("d35_5_busy_e%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("d35_5_nodone_e%0d", i), {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        chk("d35_5_busy_e10", {31'd0, busy}, 32'd0);
        chk("d35_5_done_e10", {31'd0, done}, 32'd1);
        drain("d35_5");

        issue(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0, "d100_7");   drain("d100_7");
        issue(8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0, "dm100_7");    drain("dm100_7");
        issue(8'd21, 4'hD, 8'hF9, 4'h0, 1'b0, 1'b0, "d21_m3");     drain("d21_m3");
        issue(8'hEB, 4'h8, 8'd2, 4'hB, 1'b0, 1'b0, "dm21_m8");     drain("dm21_m8");
        issue(8'd77, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, "d77_0");      drain("d77_0");
        issue(8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, "dm128_m1");   drain("dm128_m1");
        issue(8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0, "dm128_1");    drain("dm128_1");
        issue(8'hFF, 4'd7, 8'h00, 4'hF, 1'b0, 1'b0, "dm1_7");      drain("dm1_7");

        // start re-asserted mid-division must be ignored
        dcount = n_done;
        issue(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0, "ign");
        repeat (3) @(negedge clk);
        dividend = 8'd35; divisor = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("ign");
        repeat (14) @(negedge clk);
        chk("ign_done_count", n_done - dcount, 32'd1);

        // reset in the middle of a division discards it
        dcount = n_done;
        @(negedge clk);
        dividend = 8'd35; divisor = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_quot", {24'd0, quotient}, 32'd0);
        chk("mid_rst_rem",  {28'd0, remainder}, 32'd0);
        chk("mid_rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        last_q = 8'h00;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", n_done - dcount, 32'd0);
        issue(8'd127, 4'd7, 8'd18, 4'd1, 1'b0, 1'b0, "d127_7");   drain("d127_7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed two's-complement divider; the inverse of the team's combinational BoothMultiplier.
- Takes a 2N-bit dividend, the width of a multiplier product, and an N-bit divisor, the width of a multiplier operand.
- Returns a 2N-bit quotient and an N-bit remainder using a restoring shift-subtract loop, one quotient bit per clock.
- Used to check and invert products from the multiplier datapath, with a start/done handshake toward the controlling logic.

Parameters:
- N, 4, divisor/remainder width; dividend and quotient width is 2N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  signed dividend; captured on the accepting edge
- divisor  input  N  signed divisor; captured on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; results valid while high and held afterwards
- quotient  output  2N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder; sign follows the dividend
- div_by_zero  output  1  result flag: the divisor was 0
- overflow  output  1  result flag: the true quotient is not representable in 2N signed bits

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst sampled high on a clk rising edge forces state IDLE.
  - All outputs go to 0: busy, done, quotient, remainder, div_by_zero, overflow.
  - rst has priority over start and over any state, including mid-operation. An in-flight division is discarded and no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at an edge accepts the operands. On that edge the block latches sign(dividend) and sign(divisor), loads |dividend| into a 2N-bit shift register, loads |divisor| as an N+1-bit unsigned value, clears the partial remainder (N+1 bits) and the counter, sets busy=1 and goes to CALC.
  - Abs of the most-negative value is taken as an unsigned magnitude (-2^(2N-1) becomes 2^(2N-1); -2^(N-1) becomes 2^(N-1)); no truncation.
- CALC: exactly 2N edges, one per quotient bit, MSB first.
  - Shift {partial remainder, dividend register} left by 1.
  - Trial = partial remainder - |divisor|.
  - If trial is non-negative: partial remainder <= trial and the shifted-in quotient bit is 1. Otherwise the partial remainder is restored and the bit is 0.
  - After the 2N-th edge, go to FIX.
- FIX: one edge.
  - Quotient = magnitude quotient, negated if the operand signs differ.
  - Remainder = magnitude remainder, negated if the dividend is negative.
  - Register both outputs and the flags, then go to DONE.
- DONE: done=1 for exactly one cycle; busy drops to 0 on the same edge that raises done. Next edge returns to IDLE.
- Latency: done is high in the cycle following the (2N+2)th edge after the accepting edge (N=4: 10 edges after acceptance). Latency is fixed and independent of operand values, including the error cases below.
- Divide by zero: divisor=0 at acceptance.
  - The full latency still runs.
  - At FIX: quotient=0, remainder=0, div_by_zero=1, overflow=0.
- Overflow: dividend = -2^(2N-1) and divisor = -1.
  - quotient = -2^(2N-1) (wrapped bit pattern), remainder=0, overflow=1.
- Flags, quotient and remainder hold their values until the next FIX or rst. A new acceptance does not clear them early.
- start while busy (CALC/FIX/DONE) is ignored, with no queuing; operand changes during that time are ignored.
- start held high continuously begins a new division on the IDLE edge after DONE.
- Remainder range: |remainder| < |divisor| ≤ 2^(N-1), so it always fits in N signed bits.

Test Plan:
- Reset, then dividend=35, divisor=5, start pulse -> done exactly 10 edges after acceptance; quotient=7, remainder=0, flags 0; busy high for edges 1..9.
- dividend=100, divisor=7 -> quotient=14, remainder=2. dividend=-100 (8'h9C), divisor=7 -> quotient=-14 (8'hF2), remainder=-2 (4'hE).
- dividend=21, divisor=-3 -> quotient=-7 (8'hF9), remainder=0. dividend=-21, divisor=-8 -> quotient=2, remainder=-5 (4'hB).
- divisor=0, dividend=77 -> after 10 edges: quotient=0, remainder=0, div_by_zero=1. dividend=-128, divisor=-1 -> quotient=8'h80, overflow=1.
- start re-asserted with new operands at edge 4 of a division -> ignored; the first result is unchanged and only one done pulse occurs.
- rst asserted at edge 5 mid-division -> next cycle IDLE, all outputs 0, no done; a new start then completes normally.
